// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: round-robin owner of the shared snooping request bus.
// Define ARB_TIMEOUT_EN to add a watchdog that abandons a stalled ARB_WAIT.
module coherence_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SRC_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*2-1:0]          req_tx_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          bus_valid_o,
    output logic [SRC_WIDTH-1:0]          bus_source_o,
    output logic [ADDR_WIDTH-1:0]         bus_addr_o,
    output logic [1:0]                    bus_tx_o,
    input  logic                          resp_valid_i,
    input  logic [SRC_WIDTH-1:0]          resp_dest_i,
    input  logic                          resp_mem_i,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0]  TX_PUTM = 2'd2;
    localparam logic [1:0]  TX_IDLE = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BCAST = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        winner_q, winner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              tx_q, tx_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    bus_valid_q, bus_valid_d;

    logic [ADDR_WIDTH-1:0]   req_addr [NUM_REQ];
    logic [1:0]              req_tx   [NUM_REQ];
    logic [NUM_REQ-1:0]      eligible;

    logic                    pick_found;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        scan_ptr;
    int unsigned             scan_pos;

    logic                    dest_match;
    logic                    complete;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] p);
        if (32'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_addr[i] = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_tx[i]   = req_tx_i[i*2 +: 2];
            eligible[i] = req_valid_i[i] && (req_tx[i] != TX_IDLE);
        end
    end

    // Rotating scan starting at rr_ptr; positions wrap without a modulo operator.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        scan_ptr   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_pos = 32'(rr_ptr_q) + k;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            scan_ptr = PTR_W'(scan_pos);
            if (!pick_found && eligible[scan_ptr]) begin
                pick_found = 1'b1;
                pick_idx   = scan_ptr;
            end
        end
    end

    // Writebacks finish when memory answers; fills finish on a cache-directed response.
    assign dest_match = (resp_dest_i == SRC_WIDTH'(winner_q));
    assign complete   = resp_valid_i &&
                        ((tx_q == TX_PUTM) ? resp_mem_i : (dest_match && !resp_mem_i));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        grant_d     = '0;
        bus_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    winner_d          = pick_idx;
                    addr_d            = req_addr[pick_idx];
                    tx_d              = req_tx[pick_idx];
                    grant_d[pick_idx] = 1'b1;
                    bus_valid_d       = 1'b1;
                    state_d           = ARB_BCAST;
                end
            end
            ARB_BCAST: begin
                state_d = ARB_WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ARB_WAIT: begin
                if (complete) begin
                    rr_ptr_d = ptr_after(winner_q);
                    state_d  = ARB_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = ptr_after(winner_q);
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign grant_o      = grant_q;
    assign bus_valid_o  = bus_valid_q;
    assign bus_source_o = SRC_WIDTH'(winner_q);
    assign bus_addr_o   = addr_q;
    assign bus_tx_o     = tx_q;
    assign busy_o       = (state_q != ARB_IDLE);

`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
